data_memory_sized_wait: RTL and testbench
=========================================

Name: data_memory_sized_wait

Overview:
- Parametrised data memory for the MEM stage.
- Adds three things over a plain word memory:
  - configurable base address, depth and access latency;
  - byte, halfword and word accesses, with sign/zero extension on reads;
  - a ready handshake the hazard/freeze logic uses to stall the pipeline.
- Misaligned and out-of-range accesses are reported as errors instead of silently wrapping.

Parameters:
- DEPTH_WORDS, 512, number of 32-bit words stored.
- BASE_ADDR, 1024, byte address that maps to byte 0 of the array.
- WAIT_CYCLES, 3, cycles spent in BUSY per access; legal range 1..15.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous reset, active-high
- MEMread  in  1  read request
- MEMwrite  in  1  write request
- address  in  32  byte address
- data  in  32  write data, right-aligned: byte in [7:0], half in [15:0]
- size  in  2  00 byte, 01 halfword, 10 word, 11 illegal
- sign_ext  in  1  1 = sign-extend byte/half reads, 0 = zero-extend
- ready  out  1  one-cycle pulse when the access completes
- error  out  1  one-cycle pulse with ready for a rejected access
- MEM_Result  out  32  registered read data

Behaviour:
- Storage and byte order
  - Array of DEPTH_WORDS x 32 bits, little-endian byte lanes.
  - Contents are not cleared by reset.
- Address checks
  - offset = address - BASE_ADDR, 32-bit arithmetic.
  - Out of range when address < BASE_ADDR, or offset >= 4*DEPTH_WORDS.
  - Misaligned when size=01 and offset[0]=1, or size=10 and offset[1:0]!=00.
  - Word index = offset[31:2]; lane = offset[1:0].
- FSM states: IDLE, BUSY, DONE. Reset value: IDLE.
- IDLE
  - Stays in IDLE while MEMread=MEMwrite=0.
  - On a request (either strobe high) in cycle 0: latches address, data, size, sign_ext and op, loads cnt=WAIT_CYCLES, moves to BUSY.
- BUSY
  - cnt decrements each cycle.
  - On the cycle cnt==1: performs the access, moves to DONE.
  - Request inputs are ignored while BUSY.
- DONE
  - ready=1 for exactly this cycle, then returns to IDLE.
  - ready first rises in cycle WAIT_CYCLES+1 after the request was seen in IDLE.
  - The requester holds its request until ready; the pipeline advances on the ready cycle.
  - The cycle after DONE is IDLE, so a new request there is accepted immediately. Back-to-back throughput is one access per WAIT_CYCLES+2 cycles.
- Errors
  - Error causes: both strobes high, size=11, out of range, misaligned.
  - On error: no array update, MEM_Result <= 0, error=1 together with ready.
  - The error cycle still takes the full latency.
- Writes
  - Only the addressed lanes are updated: one lane for a byte, lanes {1:0} or {3:2} for a half, all four for a word.
  - Write completion leaves MEM_Result unchanged.
- Reads
  - Selects the addressed lanes, then extends to 32 bits according to sign_ext.
  - MEM_Result is registered on the BUSY->DONE edge and held until the next read completion, error or reset.
- Reset
  - Outputs: ready=0, error=0, MEM_Result=0.
  - cnt=0, FSM to IDLE.
  - Reset takes priority over every transition.
  - Reset while BUSY aborts the access: a pending write is never committed and no ready pulse follows.
- WAIT_CYCLES=1: BUSY lasts one cycle and ready appears in cycle 2.

Test Plan:
- Word write then read, WAIT_CYCLES=3:
  - Write 0xDEADBEEF to 1028; ready rises in cycle 4 after the request.
  - Word read of 1028 -> MEM_Result=0xDEADBEEF with ready, error=0.
- Byte and half access over 0x11223344 at 1032:
  - Byte read of 1035 -> 0x00000011.
  - Write byte 0xF0 to 1033, then word read of 1032 -> 0x1122F044.
  - Byte read of 1033 with sign_ext=1 -> 0xFFFFFFF0.
  - Half read of 1034 with sign_ext=0 -> 0x00001122.
- Error cases, each giving error=1 and ready after full latency, with no array change (a following word read of 1032 still returns its prior value):
  - Word read of 1030 (misaligned).
  - Half write to 1033 (misaligned).
  - Word read of 1020 (below base) -> MEM_Result=0.
  - Word read of BASE_ADDR+4*DEPTH_WORDS (past end) -> MEM_Result=0.
  - MEMread and MEMwrite both high.
- Reset mid-write:
  - Issue word write 0xCAFEF00D to 1040, assert rst during the second BUSY cycle.
  - No ready pulse; outputs return to 0.
  - Word read of 1040 after reset returns the pre-write contents.
- Back-to-back traffic:
  - Hold MEMread across two consecutive accesses, changing address on the ready cycle.
  - Ready pulses are exactly WAIT_CYCLES+2 cycles apart; each result matches its own address.
- Latency sweep:
  - Rerun the word write/read scenario with WAIT_CYCLES=1 and 15.
  - ready appears in cycles 2 and 16 respectively.

Source files
------------

// File: rtl/data_memory_sized_wait.sv
// ---------------------------------------------------------------------------
// data_memory_sized_wait
//   MEM-stage data memory with a configurable base address, depth and access
//   latency. Supports byte, halfword and word accesses (sign/zero-extended
//   reads) and reports misaligned or out-of-range accesses through an error
//   pulse rather than wrapping. A one-cycle ready pulse ends every access,
//   which the hazard/freeze logic uses to stall the pipeline.
//
// Ports
//   clk         rising-edge clock
//   rst         synchronous reset, active-high
//   MEMread     read request
//   MEMwrite    write request
//   address     byte address
//   data        write data, right-aligned (byte in [7:0], half in [15:0])
//   size        00 byte, 01 halfword, 10 word, 11 illegal
//   sign_ext    1 = sign-extend byte/half reads, 0 = zero-extend
//   ready       one-cycle pulse when the access completes
//   error       one-cycle pulse alongside ready for a rejected access
//   MEM_Result  registered read data
// ---------------------------------------------------------------------------
module data_memory_sized_wait #(
  parameter int DEPTH_WORDS = 512,
  parameter int BASE_ADDR   = 1024,
  parameter int WAIT_CYCLES = 3     // legal range 1..15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MEMread,
  input  logic        MEMwrite,
  input  logic [31:0] address,
  input  logic [31:0] data,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  output logic        ready,
  output logic        error,
  output logic [31:0] MEM_Result
);

  localparam int          IDX_W     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [31:0] BASE      = 32'(BASE_ADDR);
  localparam logic [31:0] SPAN      = 32'(4 * DEPTH_WORDS);
  localparam logic [3:0]  WAIT_LOAD = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [1:0]  size_q, size_d;
  logic        sext_q, sext_d;
  logic        rd_q, rd_d;
  logic        wr_q, wr_d;
  logic        ready_q, ready_d;
  logic        error_q, error_d;
  logic [31:0] result_q, result_d;

  logic [31:0] mem [DEPTH_WORDS];

  // Decode of the latched request
  logic [31:0]      offset;
  logic [IDX_W-1:0] idx;
  logic [1:0]       lane;
  logic             bad;
  logic [31:0]      rd_word;
  logic [31:0]      rd_val;
  logic [7:0]       rd_byte;
  logic [15:0]      rd_half;
  logic [3:0]       wr_be;
  logic [31:0]      wr_word;
  logic             access;
  logic             wr_en;

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    offset  = addr_q - BASE;
    idx     = offset[IDX_W+1:2];
    lane    = offset[1:0];
    // The below-base test catches the wrap of offset for small addresses.
    bad     = (rd_q && wr_q) || (size_q == 2'b11) || (addr_q < BASE) ||
              (offset >= SPAN) || ((size_q == 2'b01) && offset[0]) ||
              ((size_q == 2'b10) && (lane != 2'b00));
    rd_word = mem[idx];
    rd_byte = rd_word[{lane, 3'b000} +: 8];
    rd_half = lane[1] ? rd_word[31:16] : rd_word[15:0];
    rd_val  = rd_word;
    wr_be   = 4'b1111;
    wr_word = wdata_q;
    case (size_q)
      2'b00: begin
        rd_val  = {{24{sext_q & rd_byte[7]}}, rd_byte};
        wr_be   = 4'b0001 << lane;
        wr_word = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        rd_val  = {{16{sext_q & rd_half[15]}}, rd_half};
        wr_be   = lane[1] ? 4'b1100 : 4'b0011;
        wr_word = {2{wdata_q[15:0]}};
      end
      default: ;
    endcase
    access = (state_q == BUSY) && (cnt_q == 4'd1);
    wr_en  = access && wr_q && !bad;
  end

  // Next-state and output logic
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    size_d   = size_q;
    sext_d   = sext_q;
    rd_d     = rd_q;
    wr_d     = wr_q;
    ready_d  = 1'b0;
    error_d  = 1'b0;
    result_d = result_q;
    case (state_q)
      IDLE: begin
        if (MEMread || MEMwrite) begin
          addr_d  = address;
          wdata_d = data;
          size_d  = size;
          sext_d  = sign_ext;
          rd_d    = MEMread;
          wr_d    = MEMwrite;
          cnt_d   = WAIT_LOAD;
          state_d = BUSY;
        end
      end
      BUSY: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = DONE;
          ready_d = 1'b1;
          error_d = bad;
          if (bad)       result_d = '0;
          else if (rd_q) result_d = rd_val;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      size_q   <= '0;
      sext_q   <= 1'b0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      ready_q  <= 1'b0;
      error_q  <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      size_q   <= size_d;
      sext_q   <= sext_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      ready_q  <= ready_d;
      error_q  <= error_d;
      result_q <= result_d;
    end
  end

  // NOTE: the storage array has no reset; contents survive rst. Gating the
  // write with !rst is what aborts a write caught by reset on its commit edge.
  always_ff @(posedge clk) begin
    if (!rst && wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (wr_be[i]) mem[idx][8*i +: 8] <= wr_word[8*i +: 8];
      end
    end
  end

  assign ready      = ready_q;
  assign error      = error_q;
  assign MEM_Result = result_q;

endmodule

// File: tb/tb_data_memory_sized_wait.sv
// ---------------------------------------------------------------------------
// tb_data_memory_sized_wait
//   Directed and random accesses against a byte-array reference model.
//   Three instances share the request inputs: the WAIT_CYCLES=3 instance is
//   the main target, the 1 and 15 instances serve the latency sweep at the end.
// ---------------------------------------------------------------------------
module tb_data_memory_sized_wait;

  localparam int          W     = 3;
  localparam int          DEPTH = 512;
  localparam logic [31:0] BASE  = 32'd1024;
  localparam logic [31:0] SPAN  = 32'd2048;

  logic        clk = 1'b0;
  logic        rst;
  logic        MEMread, MEMwrite, sign_ext;
  logic [31:0] address, data;
  logic [1:0]  size;
  logic        ready, error;
  logic [31:0] mem_result;
  logic        r1, e1, r15, e15;
  logic [31:0] m1, m15;

  int checks = 0;
  int errors = 0;

  logic [7:0]  mref [0:4*DEPTH-1];
  logic [31:0] ref_res;

  always #5 clk = ~clk;

  data_memory_sized_wait #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(1024), .WAIT_CYCLES(W)) dut (
    .clk(clk), .rst(rst), .MEMread(MEMread), .MEMwrite(MEMwrite), .address(address),
    .data(data), .size(size), .sign_ext(sign_ext), .ready(ready), .error(error),
    .MEM_Result(mem_result));

  data_memory_sized_wait #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(1024), .WAIT_CYCLES(1)) dut_w1 (
    .clk(clk), .rst(rst), .MEMread(MEMread), .MEMwrite(MEMwrite), .address(address),
    .data(data), .size(size), .sign_ext(sign_ext), .ready(r1), .error(e1),
    .MEM_Result(m1));

  data_memory_sized_wait #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(1024), .WAIT_CYCLES(15)) dut_w15 (
    .clk(clk), .rst(rst), .MEMread(MEMread), .MEMwrite(MEMwrite), .address(address),
    .data(data), .size(size), .sign_ext(sign_ext), .ready(r15), .error(e15),
    .MEM_Result(m15));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Reference: a flat byte array; result register follows the access rules.
  task automatic model(input logic rd, input logic wr, input logic [31:0] a,
                       input logic [31:0] d, input logic [1:0] sz, input logic sx,
                       output logic err);
    logic [31:0] off, v;
    int nb;
    off = a - BASE;
    nb  = 1 << sz;
    err = (rd && wr) || (sz == 2'b11) || (a < BASE) || (off >= SPAN) ||
          (sz == 2'b01 && off[0]) || (sz == 2'b10 && off[1:0] != 2'b00);
    if (err) begin
      ref_res = 32'h0;
    end else if (wr) begin
      for (int i = 0; i < nb; i++) mref[int'(off) + i] = d[8*i +: 8];
    end else begin
      v = 32'h0;
      for (int i = 0; i < nb; i++) v = v | (32'(mref[int'(off) + i]) << (8*i));
      if (sx && nb < 4 && v[8*nb-1]) v = v | (32'hFFFF_FFFF << (8*nb));
      ref_res = v;
    end
  endtask

  task automatic drive(input logic rd, input logic wr, input logic [31:0] a,
                       input logic [31:0] d, input logic [1:0] sz, input logic sx);
    MEMread  = rd;
    MEMwrite = wr;
    address  = a;
    data     = d;
    size     = sz;
    sign_ext = sx;
  endtask

  // Bounded wait for the main instance's ready; returns edges counted.
  task automatic wait_ready(output int n);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!ready && n < 40);
  endtask

  // One access from IDLE: latency, error flag, result, single-cycle pulse.
  task automatic do_access(input logic rd, input logic wr, input logic [31:0] a,
                           input logic [31:0] d, input logic [1:0] sz, input logic sx,
                           input string tag);
    logic exp_err;
    int n;
    model(rd, wr, a, d, sz, sx, exp_err);
    drive(rd, wr, a, d, sz, sx);
    wait_ready(n);
    check({tag, "/latency"}, 32'(n), 32'(W + 1));
    check({tag, "/error"}, {31'h0, error}, {31'h0, exp_err});
    check({tag, "/result"}, mem_result, ref_res);
    drive(1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 1'b0);
    @(posedge clk); #1;
    check({tag, "/pulse_end"}, {30'h0, ready, error}, 32'h0);
  endtask

  initial begin
    int n, n2, lat1, lat15;
    logic exp_err;
    logic [31:0] cap1, cap15;
    logic rd, wr, sx;
    logic [1:0] sz;
    logic [31:0] a;
    int pick;

    rst = 1'b1;
    drive(1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 1'b0);
    ref_res = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    check("reset/ready", {31'h0, ready}, 32'h0);
    check("reset/error", {31'h0, error}, 32'h0);
    check("reset/result", mem_result, 32'h0);
    rst = 1'b0;

    // Fill the first 64 bytes so every later read hits known data.
    for (int i = 0; i < 16; i++)
      do_access(1'b0, 1'b1, BASE + 32'(4*i), $urandom, 2'b10, 1'b0, "init");

    // Word write/read
    do_access(1'b0, 1'b1, 32'd1028, 32'hDEADBEEF, 2'b10, 1'b0, "wr1028");
    do_access(1'b1, 1'b0, 32'd1028, 32'h0, 2'b10, 1'b0, "rd1028");
    check("rd1028/const", mem_result, 32'hDEADBEEF);

    // Byte and half accesses
    do_access(1'b0, 1'b1, 32'd1032, 32'h11223344, 2'b10, 1'b0, "wr1032");
    do_access(1'b1, 1'b0, 32'd1035, 32'h0, 2'b00, 1'b0, "rdb1035");
    check("rdb1035/const", mem_result, 32'h00000011);
    do_access(1'b0, 1'b1, 32'd1033, 32'h000000F0, 2'b00, 1'b0, "wrb1033");
    do_access(1'b1, 1'b0, 32'd1032, 32'h0, 2'b10, 1'b0, "rd1032");
    check("rd1032/const", mem_result, 32'h1122F044);
    do_access(1'b1, 1'b0, 32'd1033, 32'h0, 2'b00, 1'b1, "rdb1033s");
    check("rdb1033s/const", mem_result, 32'hFFFFFFF0);
    do_access(1'b1, 1'b0, 32'd1034, 32'h0, 2'b01, 1'b0, "rdh1034");
    check("rdh1034/const", mem_result, 32'h00001122);

    // Rejected accesses
    do_access(1'b1, 1'b0, 32'd1030, 32'h0, 2'b10, 1'b0, "err_misw");
    check("err_misw/flag", {31'h0, error}, 32'h0);  // pulse already over
    do_access(1'b0, 1'b1, 32'd1033, 32'h0000ABCD, 2'b01, 1'b0, "err_mish");
    do_access(1'b1, 1'b0, 32'd1020, 32'h0, 2'b10, 1'b0, "err_below");
    check("err_below/const", mem_result, 32'h0);
    do_access(1'b1, 1'b0, BASE + SPAN, 32'h0, 2'b10, 1'b0, "err_past");
    check("err_past/const", mem_result, 32'h0);
    do_access(1'b1, 1'b1, 32'd1032, 32'h55555555, 2'b10, 1'b0, "err_both");
    do_access(1'b1, 1'b0, 32'd1032, 32'h0, 2'b10, 1'b0, "rd1032_after");
    check("rd1032_after/const", mem_result, 32'h1122F044);

    // Reset during the second BUSY cycle of a write
    drive(1'b0, 1'b1, 32'd1040, 32'hCAFEF00D, 2'b10, 1'b0);
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b1;
    drive(1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 1'b0);
    @(posedge clk); #1;
    check("rstmid/outputs", {30'h0, ready, error}, 32'h0);
    check("rstmid/result", mem_result, 32'h0);
    ref_res = 32'h0;
    rst = 1'b0;
    n = 0;
    repeat (W + 3) begin
      @(posedge clk); #1;
      if (ready) n++;
    end
    check("rstmid/no_ready", 32'(n), 32'h0);
    do_access(1'b1, 1'b0, 32'd1040, 32'h0, 2'b10, 1'b0, "rstmid_rd");

    // Back-to-back reads with MEMread held, address changed on ready
    model(1'b1, 1'b0, 32'd1032, 32'h0, 2'b10, 1'b0, exp_err);
    drive(1'b1, 1'b0, 32'd1032, 32'h0, 2'b10, 1'b0);
    wait_ready(n);
    check("b2b/first_lat", 32'(n), 32'(W + 1));
    check("b2b/first_res", mem_result, ref_res);
    model(1'b1, 1'b0, 32'd1028, 32'h0, 2'b10, 1'b0, exp_err);
    address = 32'd1028;
    wait_ready(n2);
    check("b2b/spacing", 32'(n2), 32'(W + 2));
    check("b2b/second_res", mem_result, ref_res);
    drive(1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 1'b0);
    @(posedge clk); #1;

    // Random traffic, mostly inside the initialised window
    for (int k = 0; k < 80; k++) begin
      pick = int'($urandom_range(0, 9));
      rd = (pick == 0) || (pick >= 5);
      wr = (pick <= 4);
      sz = 2'($urandom_range(0, 3));
      sx = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 9) == 0)
        a = ($urandom_range(0, 1) == 0) ? BASE - 32'($urandom_range(1, 8))
                                         : BASE + SPAN + 32'($urandom_range(0, 7));
      else
        a = BASE + 32'($urandom_range(0, 63));
      do_access(rd, wr, a, $urandom, sz, sx, "rand");
    end

    // Latency sweep (last: the shared inputs also disturb the main instance)
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    drive(1'b0, 1'b1, 32'd1028, 32'h0BADF00D, 2'b10, 1'b0);
    lat1 = 0; lat15 = 0; n = 0;
    while ((lat1 == 0 || lat15 == 0) && n < 40) begin
      @(posedge clk); #1;
      n++;
      if (r1 && lat1 == 0) lat1 = n;
      if (r15 && lat15 == 0) lat15 = n;
    end
    check("sweep/lat_w1", 32'(lat1), 32'd2);
    check("sweep/lat_w15", 32'(lat15), 32'd16);
    drive(1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 1'b0);
    repeat (20) @(posedge clk);
    #1;
    drive(1'b1, 1'b0, 32'd1028, 32'h0, 2'b10, 1'b0);
    cap1 = 32'h0; cap15 = 32'h0; lat1 = 0; lat15 = 0; n = 0;
    while ((lat1 == 0 || lat15 == 0) && n < 40) begin
      @(posedge clk); #1;
      n++;
      if (r1 && lat1 == 0) begin lat1 = n; cap1 = m1; end
      if (r15 && lat15 == 0) begin lat15 = n; cap15 = m15; end
    end
    check("sweep/rd_lat_w1", 32'(lat1), 32'd2);
    check("sweep/rd_lat_w15", 32'(lat15), 32'd16);
    check("sweep/rd_w1", cap1, 32'h0BADF00D);
    check("sweep/rd_w15", cap15, 32'h0BADF00D);
    check("sweep/err", {30'h0, e1, e15}, 32'h0);
    drive(1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
